// File: rtl/gpio_param_writer.sv
// GPIO command decoder: synchronizes a strobe-toggled command word and
// assembles 16-bit halves into stored 32-bit parameters.
//   CLK, RST     : clock, synchronous active-high reset
//   GP_IN        : command word (async to CLK)
//   SET          : parameter-set ID this instance answers to
//   PARAMS_DATA  : stored parameters, word i at [i*32 +: 32]
//   ACK          : STROBE value of the last accepted command
//   WR_PULSE     : one-cycle pulse on each commit
//   WR_INDEX     : index of the last commit
//   ERR          : sticky protocol-error flag
module gpio_param_writer #(
  parameter int GPIO_WIDTH  = 32,
  parameter int PARAM_COUNT = 16
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [GPIO_WIDTH-1:0]             GP_IN,
  input  logic [3:0]                        SET,
  output logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAMS_DATA,
  output logic                              ACK,
  output logic                              WR_PULSE,
  output logic [3:0]                        WR_INDEX,
  output logic                              ERR
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_LOW_HELD = 1'b1;

  logic [GPIO_WIDTH-1:0] q1_q, q2_q;
  logic                  strobe_prev_q;
  logic [0:0]            state_q, state_d;
  logic [15:0]           stage_data_q, stage_data_d;
  logic [3:0]            stage_idx_q, stage_idx_d;
  logic [PARAM_COUNT*GPIO_WIDTH-1:0] params_q, params_d;
  logic                  ack_q, ack_d;
  logic                  pulse_q, pulse_d;
  logic [3:0]            widx_q, widx_d;
  logic                  err_q, err_d;

  logic        strobe, high, clr, idx_ok, match, commit, new_err;
  logic [3:0]  set_f, idx;
  logic [15:0] data;
  logic        unused_bits;

  assign strobe = q2_q[31];
  assign high   = q2_q[30];
  assign clr    = q2_q[28];
  assign set_f  = q2_q[27:24];
  assign data   = q2_q[19:4];
  assign idx    = q2_q[3:0];

  assign unused_bits = ^{q2_q[29], q2_q[23:20]};

  assign idx_ok = {1'b0, idx} < 5'(PARAM_COUNT);

  // An event is any strobe edge seen at the synchronizer output.
  assign match = (strobe != strobe_prev_q) && (set_f == SET);

  always_comb begin
    state_d      = state_q;
    stage_data_d = stage_data_q;
    stage_idx_d  = stage_idx_q;
    params_d     = params_q;
    ack_d        = ack_q;
    pulse_d      = 1'b0;
    widx_d       = widx_q;
    err_d        = err_q;
    commit       = 1'b0;
    new_err      = 1'b0;

    if (match) begin
      ack_d = strobe;
      unique case (1'b1)
        (!high && !idx_ok): begin
          new_err = 1'b1;
          state_d = S_IDLE;
        end
        (!high && idx_ok): begin
          stage_data_d = data;
          stage_idx_d  = idx;
          state_d      = S_LOW_HELD;
        end
        high: begin
          commit  = (state_q == S_LOW_HELD) &&
                    (idx == stage_idx_q) && idx_ok;
          new_err = !commit;
          state_d = S_IDLE;
        end
        default: ;
      endcase

      // A new error in the same event wins over a clear.
      if (clr)     err_d = 1'b0;
      if (new_err) err_d = 1'b1;

      if (commit) begin
        pulse_d = 1'b1;
        widx_d  = idx;
      end
    end

    for (int i = 0; i < PARAM_COUNT; i++) begin
      if (commit && idx == 4'(i))
        params_d[i*GPIO_WIDTH +: GPIO_WIDTH] = {data, stage_data_q};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q1_q          <= '0;
      q2_q          <= '0;
      strobe_prev_q <= 1'b0;
      state_q       <= S_IDLE;
      stage_data_q  <= '0;
      stage_idx_q   <= '0;
      params_q      <= '0;
      ack_q         <= 1'b0;
      pulse_q       <= 1'b0;
      widx_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      q1_q          <= GP_IN;
      q2_q          <= q1_q;
      strobe_prev_q <= q2_q[31];
      state_q       <= state_d;
      stage_data_q  <= stage_data_d;
      stage_idx_q   <= stage_idx_d;
      params_q      <= params_d;
      ack_q         <= ack_d;
      pulse_q       <= pulse_d;
      widx_q        <= widx_d;
      err_q         <= err_d;
    end
  end

  assign PARAMS_DATA = params_q;
  assign ACK         = ack_q;
  assign WR_PULSE    = pulse_q;
  assign WR_INDEX    = widx_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_gpio_param_writer.sv
// Scoreboard bench for gpio_param_writer (PARAM_COUNT=8, SET=3).
// Expected outputs are queued per command and popped at edge 3.
module tb_gpio_param_writer;

  localparam int PC = 8;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic [31:0]   GP_IN = '0;
  logic [3:0]    SET = 4'd3;
  logic [PC*32-1:0] PARAMS_DATA;
  logic          ACK, WR_PULSE, ERR;
  logic [3:0]    WR_INDEX;

  gpio_param_writer #(.GPIO_WIDTH(32), .PARAM_COUNT(PC)) dut (
    .CLK(clk), .RST(RST), .GP_IN(GP_IN), .SET(SET),
    .PARAMS_DATA(PARAMS_DATA), .ACK(ACK), .WR_PULSE(WR_PULSE),
    .WR_INDEX(WR_INDEX), .ERR(ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ack;
    logic         err;
    logic         pulse;
    logic [3:0]   widx;
    logic [255:0] par;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic        m_prev, m_low, m_ack, m_err, tog, ack_before;
  logic [15:0] m_sdata;
  logic [3:0]  m_sidx, m_widx;
  logic [31:0] m_par[PC];

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(logic s, logic hi, logic clr,
      logic [3:0] st, logic [15:0] d, logic [3:0] ix);
    return {s, hi, 1'b0, clr, st, 4'b0, d, ix};
  endfunction

  function automatic logic [255:0] flat();
    logic [255:0] f = '0;
    for (int i = 0; i < PC; i++) f[i*32 +: 32] = m_par[i];
    return f;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_low = 0; m_ack = 0; m_err = 0;
    m_sdata = '0; m_sidx = '0; m_widx = '0;
    for (int i = 0; i < PC; i++) m_par[i] = '0;
  endtask

  task automatic model(input logic [31:0] c);
    exp_t e;
    logic ne;
    logic ok;
    e.pulse = 0;
    ne = 0;
    ok = c[3:0] < 4'(PC);
    if (c[31] != m_prev && c[27:24] == SET) begin
      m_ack = c[31];
      if (!c[30]) begin
        if (!ok) begin ne = 1; m_low = 0; end
        else begin m_sdata = c[19:4]; m_sidx = c[3:0]; m_low = 1; end
      end else begin
        if (m_low && c[3:0] == m_sidx && ok) begin
          m_par[c[3:0]] = {c[19:4], m_sdata};
          m_widx = c[3:0];
          e.pulse = 1;
        end else ne = 1;
        m_low = 0;
      end
      if (c[28]) m_err = 0;
      if (ne) m_err = 1;
    end
    m_prev = c[31];
    e.ack = m_ack; e.err = m_err; e.widx = m_widx; e.par = flat();
    sb.push_back(e);
  endtask

  task automatic run_ev();
    exp_t e;
    @(posedge clk);
    @(posedge clk); #1;
    chk("ack_latency", ACK, ack_before);
    chk("pulse_latency", WR_PULSE, 0);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("ack", ACK, e.ack);
      chk("err", ERR, e.err);
      chk("wr_pulse", WR_PULSE, e.pulse);
      chk("wr_index", WR_INDEX, e.widx);
      chk("params", PARAMS_DATA, e.par);
    end
    @(posedge clk); #1;
    chk("pulse_off", WR_PULSE, 0);
  endtask

  task automatic send(input logic hi, input logic clr, input logic [3:0] st,
                      input logic [15:0] d, input logic [3:0] ix);
    logic [31:0] c;
    tog = ~tog;
    c = mk(tog, hi, clr, st, d, ix);
    @(negedge clk);
    GP_IN = c;
    ack_before = m_ack;
    model(c);
    run_ev();
  endtask

  task automatic rst_seq(input logic [31:0] c);
    @(negedge clk);
    GP_IN = c;
    RST = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ACK, 0);
    chk("rst_err", ERR, 0);
    chk("rst_pulse", WR_PULSE, 0);
    chk("rst_widx", WR_INDEX, 0);
    chk("rst_params", PARAMS_DATA, 0);
    @(negedge clk);
    RST = 0;
    model_reset();
    tog = c[31];
    ack_before = 0;
    model(c);
    run_ev();
  endtask

  initial begin
    model_reset();
    tog = 0;
    rst_seq('0);

    send(0, 0, 3, 16'h1234, 2);
    send(1, 0, 3, 16'hABCD, 2);

    send(1, 0, 3, 16'h5555, 1);
    send(0, 1, 3, 16'h7777, 1);
    send(1, 0, 3, 16'h8888, 1);

    send(0, 0, 5, 16'h9999, 3);
    send(1, 0, 5, 16'h9999, 3);

    send(1, 0, 3, 16'h0101, 2);
    send(1, 1, 3, 16'h0202, 2);
    send(0, 1, 3, 16'h0303, 6);
    send(0, 0, 3, 16'h0404, 9);
    send(0, 1, 3, 16'h0505, 8);
    send(0, 1, 3, 16'h0606, 1);
    send(1, 0, 3, 16'h0707, 4);
    send(0, 1, 3, 16'hBEEF, 7);
    send(1, 0, 3, 16'hDEAD, 7);

    send(0, 0, 3, 16'h1111, 0);
    send(0, 0, 3, 16'h2222, 0);
    send(1, 0, 3, 16'h0000, 0);

    send(0, 0, 3, 16'h3333, 3);
    rst_seq('0);
    send(1, 0, 3, 16'h4444, 3);

    rst_seq(mk(1, 0, 0, 3, 16'h5A5A, 5));
    send(1, 0, 3, 16'hC3C3, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_param_writer.md
GPIO_PARAM_WRITER -- requirements
Module: gpio_param_writer

Interface
REQ-001 The block SHALL have parameter GPIO_WIDTH, default 32, GPIO word width; only 32 is supported.
REQ-002 The block SHALL have parameter PARAM_COUNT, default 16, number of stored parameters; legal range 1..16.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 GP_IN  input  GPIO_WIDTH  command word from the processor GPIO, asynchronous to CLK.
REQ-006 SET  input  4  parameter-set ID of this instance.
REQ-007 PARAMS_DATA  output  PARAM_COUNT*GPIO_WIDTH  stored parameters; parameter i occupies bits [i*32 +: 32].
REQ-008 ACK  output  1  toggle; equals the STROBE value of the last accepted command.
REQ-009 WR_PULSE  output  1  one-cycle pulse on each parameter commit.
REQ-010 WR_INDEX  output  4  index of the last committed parameter.
REQ-011 ERR  output  1  sticky protocol-error flag.

Function
REQ-012 GP_IN fields SHALL be: [31] STROBE, [30] HIGH (0 low half, 1 high half), [29] readback enable (ignored here), [28] CLR_ERR, [27:24] set, [23:20] reserved (ignored), [19:4] DATA16, [3:0] index.
REQ-013 The entire GP_IN word SHALL pass through a two-register synchronizer (q1, q2); all decoding SHALL use q2 only.
REQ-014 An event SHALL occur in any cycle where q2[31] differs from register strobe_prev; strobe_prev SHALL load q2[31] every cycle.
REQ-015 An event whose set field differs from SET SHALL be ignored entirely: no state, ACK, ERR or data change.
REQ-016 A matched event SHALL set ACK to q2[31] and, if CLR_ERR=1, clear ERR; a clear and a new error in the same event SHALL leave ERR = 1.
REQ-017 The FSM SHALL have two states, IDLE and LOW_HELD.
REQ-018 In IDLE, a low-half event SHALL load stage_data = DATA16 and stage_idx = index, and go to LOW_HELD.
REQ-019 In IDLE, a high-half event SHALL set ERR, write nothing, and stay in IDLE.
REQ-020 In LOW_HELD, a low-half event SHALL overwrite stage_data and stage_idx and stay in LOW_HELD.
REQ-021 In LOW_HELD, a high-half event with index == stage_idx and index < PARAM_COUNT SHALL:
  - write {DATA16, stage_data} to parameter index;
  - set WR_INDEX = index;
  - pulse WR_PULSE for one cycle;
  - go to IDLE.
REQ-022 In LOW_HELD, a high-half event with an index mismatch, or with index >= PARAM_COUNT, SHALL set ERR, write nothing, and go to IDLE.
REQ-023 A low-half event with index >= PARAM_COUNT SHALL set ERR and go to or stay in IDLE.
REQ-024 Latency: with a new GP_IN value sampled into q1 at edge 1, q2 updates at edge 2 and PARAMS_DATA, WR_PULSE and ACK update at edge 3.
REQ-025 Only one event per STROBE toggle SHALL be processed; toggles closer than 1 cycle apart in q2 are outside the contract.
REQ-026 Unwritten parameters SHALL hold their value; all other parameters SHALL be unaffected by a commit.
REQ-027 WR_PULSE SHALL be 0 in every cycle without a commit.

Reset
REQ-028 RST=1 at a rising edge SHALL clear q1, q2, strobe_prev, stage_data, stage_idx, all PARAMS_DATA words, ACK, WR_PULSE, WR_INDEX and ERR to 0, and force the FSM to IDLE.
REQ-029 Reset mid-sequence (LOW_HELD) SHALL discard the staged half with no commit.
REQ-030 If GP_IN[31] = 1 when RST deasserts, exactly one event SHALL be processed once it reaches q2.

Verification
REQ-031 SET=3; low event idx 2, data 0x1234, STROBE 0->1; then high event idx 2, data 0xABCD, STROBE 1->0 -> parameter 2 = 0xABCD1234, WR_PULSE for 1 cycle at edge 3 of the second event, WR_INDEX=2, ACK=0, ERR=0.
REQ-032 High event with no prior low, set matched -> ERR=1, PARAMS_DATA unchanged, ACK follows STROBE; a following low event with CLR_ERR=1 -> ERR=0.
REQ-033 Event with set=5 while SET=3 -> no change to ACK, ERR, FSM or data.
REQ-034 PARAM_COUNT=8; low event idx 9 -> ERR=1, FSM IDLE; low idx 1 then high idx 4 -> ERR=1, no write to either index.
REQ-035 Low event accepted, then RST pulsed 1 cycle, then high event idx same -> ERR=1, no write, all outputs 0 during and immediately after reset.
REQ-036 Two low events (idx 0, data 0x1111 then 0x2222) then high 0x0000 -> parameter 0 = 0x00002222.
